mem_access: RTL and testbench

Multi-cycle load/store engine for the reference CPU, directly downstream of address checking. Once an instruction's effective address is validated (aligned, size known), this block issues one data-bus transaction, sequences the address and data handshakes, and returns lane-extracted, sign- or zero-extended load data or a store-complete pulse to the control FSM. One transaction is in flight at a time; it sits between the CPU state machine (S_LOAD/S_STORE) and the dbus.

---
 rtl/mem_access.sv | 150 +++++++++++++++
 tb/tb_mem_access.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Single-outstanding load/store engine between the CPU control FSM and the data bus.
// state | meaning
// IDLE  | waiting for start; request fields latched on start
// REQ   | dreq_valid high, holding request until dresp_addr_ok
// WAIT  | address accepted, waiting for dresp_data_ok
// DONE  | one-cycle done pulse, then back to IDLE
module mem_access #(
  parameter bit REPLICATE_WDATA = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_ext_q, sign_ext_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [4:0]  lane_shift;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;
  logic [3:0]  strobe_raw;
  logic        capture;

  assign lane_shift = {addr_q[1:0], 3'b000};

  // Load lane extraction and extension, driven only into rdata_q.
  always_comb begin
    load_shifted = dresp_data >> lane_shift;
    case (size_q)
      2'd0:    load_ext = {{24{sign_ext_q & load_shifted[7]}},  load_shifted[7:0]};
      2'd1:    load_ext = {{16{sign_ext_q & load_shifted[15]}}, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    addr_d     = addr_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    wdata_d    = wdata_q;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          addr_d     = addr;
          size_d     = size;
          sign_ext_d = sign_ext;
          wdata_d    = wdata;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dresp_data_ok) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdata_d = (capture && !is_store_q) ? load_ext : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      sign_ext_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Request fields decode only from latched registers, never from dresp_*.
  always_comb begin
    case (size_q)
      2'd0:    strobe_raw = 4'b0001 << addr_q[1:0];
      2'd1:    strobe_raw = 4'b0011 << addr_q[1:0];
      default: strobe_raw = 4'b1111;
    endcase
    dreq_strobe = is_store_q ? strobe_raw : 4'b0000;
    if (REPLICATE_WDATA) begin
      case (size_q)
        2'd0:    dreq_data = {4{wdata_q[7:0]}};
        2'd1:    dreq_data = {2{wdata_q[15:0]}};
        default: dreq_data = wdata_q;
      endcase
    end else begin
      dreq_data = wdata_q << lane_shift;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign dreq_valid = (state_q == ST_REQ);
  assign dreq_addr  = addr_q;
  assign dreq_size  = size_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: inputs driven and outputs sampled 1ns after each rising edge.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        is_store;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int txn_cnt = 0;

  mem_access dut (
    .clk(clk), .resetn(resetn), .start(start), .is_store(is_store), .addr(addr),
    .size(size), .sign_ext(sign_ext), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt++;
    if (dreq_valid && dresp_addr_ok) txn_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 32'h0;
  endtask

  // Pulses start for one cycle; on return the DUT is in REQ.
  task automatic issue(input logic st, input logic [31:0] a, input logic [1:0] sz,
                       input logic sx, input logic [31:0] wd);
    start = 1'b1; is_store = st; addr = a; size = sz; sign_ext = sx; wdata = wd;
    tick();
    start = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h1111_1111;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; is_store = 1'b0; addr = '0; size = '0;
    sign_ext = 1'b0; wdata = '0; bus_idle();
    tick(); tick();
    if ({busy, done, dreq_valid} !== 3'b000) begin
      $display("FAIL reset_ctrl: busy/done/valid=%b expected 000", {busy, done, dreq_valid}); fails++;
    end
    tests++;
    if (rdata !== 32'h0 || dreq_strobe !== 4'h0) begin
      $display("FAIL reset_data: rdata=%h strobe=%b expected 0/0000", rdata, dreq_strobe); fails++;
    end
    tests++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_word_load();
    issue(1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'h0);
    if (!(dreq_valid === 1'b1 && busy === 1'b1 && dreq_addr === 32'h1000 && dreq_size === 2'd2
          && dreq_strobe === 4'b0000)) begin
      $display("FAIL wl_req: valid=%b busy=%b addr=%h size=%0d strobe=%b expected 1 1 1000 2 0000",
               dreq_valid, busy, dreq_addr, dreq_size, dreq_strobe); fails++;
    end
    tests++;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hDEAD_BEEF;
    tick();
    bus_idle();
    if (done !== 1'b1 || rdata !== 32'hDEAD_BEEF || dreq_valid !== 1'b0) begin
      $display("FAIL wl_done: done=%b rdata=%h valid=%b expected 1 deadbeef 0", done, rdata, dreq_valid); fails++;
    end
    tests++;
    tick();
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL wl_idle: done=%b busy=%b expected 0 0", done, busy); fails++;
    end
    tests++;
  endtask

  task automatic byte_load_stalled(input logic sx, input logic [31:0] exp);
    int stable_cycles = 0;
    issue(1'b0, 32'h0000_1003, 2'd0, sx, 32'h0);
    for (int i = 0; i < 3; i++) begin
      dresp_data_ok = (i == 1);
      dresp_data = 32'h1234_5678;
      if (dreq_valid === 1'b1 && dreq_addr === 32'h1003 && dreq_size === 2'd0) stable_cycles++;
      tick();
    end
    if (dreq_valid === 1'b1 && dreq_addr === 32'h1003) stable_cycles++;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0;
    tick();
    dresp_addr_ok = 1'b0;
    if (stable_cycles !== 4 || dreq_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL bl_stall sx=%0d: stable=%0d valid=%b busy=%b expected 4 0 1",
               sx, stable_cycles, dreq_valid, busy); fails++;
    end
    tests++;
    tick(); tick();
    if (done !== 1'b0) begin
      $display("FAIL bl_wait sx=%0d: done=%b expected 0", sx, done); fails++;
    end
    tests++;
    dresp_data_ok = 1'b1; dresp_data = 32'h80FF_0102;
    tick();
    bus_idle();
    if (done !== 1'b1 || rdata !== exp) begin
      $display("FAIL bl_data sx=%0d: done=%b rdata=%h expected 1 %h", sx, done, rdata, exp); fails++;
    end
    tests++;
    tick();
  endtask

  task automatic test_byte_load();
    byte_load_stalled(1'b1, 32'hFFFF_FF80);
    byte_load_stalled(1'b0, 32'h0000_0080);
  endtask

  task automatic test_half_store();
    issue(1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_ABCD);
    if (dreq_strobe !== 4'b1100 || dreq_data !== 32'hABCD_ABCD || dreq_addr !== 32'h2002) begin
      $display("FAIL hs_req: strobe=%b data=%h addr=%h expected 1100 abcdabcd 2002",
               dreq_strobe, dreq_data, dreq_addr); fails++;
    end
    tests++;
    dresp_addr_ok = 1'b1; dresp_data = 32'h5555_5555;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b1;
    tick();
    bus_idle();
    if (done !== 1'b1 || rdata !== 32'h0000_0080) begin
      $display("FAIL hs_done: done=%b rdata=%h expected 1 00000080", done, rdata); fails++;
    end
    tests++;
    tick();
  endtask

  task automatic test_start_in_wait();
    int d0 = done_cnt;
    int t0 = txn_cnt;
    issue(1'b0, 32'h0000_3000, 2'd2, 1'b0, 32'h0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    start = 1'b1; addr = 32'h0000_3004; size = 2'd2;
    tick();
    start = 1'b0;
    dresp_data_ok = 1'b1; dresp_data = 32'hCAFE_F00D;
    tick();
    bus_idle();
    tick(); tick(); tick();
    if (done_cnt - d0 !== 1 || txn_cnt - t0 !== 1 || busy !== 1'b0 || rdata !== 32'hCAFE_F00D) begin
      $display("FAIL siw: dones=%0d txns=%0d busy=%b rdata=%h expected 1 1 0 cafef00d",
               done_cnt - d0, txn_cnt - t0, busy, rdata); fails++;
    end
    tests++;
  endtask

  task automatic test_reset_in_wait();
    int d0 = done_cnt;
    issue(1'b0, 32'h0000_5000, 2'd2, 1'b0, 32'h0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    if (busy !== 1'b0 || dreq_valid !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
      $display("FAIL rst_wait: busy=%b valid=%b done=%b rdata=%h expected 0 0 0 0",
               busy, dreq_valid, done, rdata); fails++;
    end
    tests++;
    dresp_data_ok = 1'b1; dresp_data = 32'h9999_9999;
    tick();
    bus_idle();
    tick();
    if (done_cnt !== d0 || busy !== 1'b0 || rdata !== 32'h0) begin
      $display("FAIL rst_stray: dones=%0d busy=%b rdata=%h expected 0 0 0",
               done_cnt - d0, busy, rdata); fails++;
    end
    tests++;
  endtask

  task automatic test_back_to_back();
    int t0 = txn_cnt;
    issue(1'b1, 32'h0000_4001, 2'd0, 1'b0, 32'h0000_005A);
    if (dreq_strobe !== 4'b0010 || dreq_data !== 32'h5A5A_5A5A) begin
      $display("FAIL b2b_st: strobe=%b data=%h expected 0010 5a5a5a5a", dreq_strobe, dreq_data); fails++;
    end
    tests++;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    bus_idle();
    if (done !== 1'b1) begin
      $display("FAIL b2b_done1: done=%b expected 1", done); fails++;
    end
    tests++;
    tick();
    if (busy !== 1'b0 || dreq_valid !== 1'b0) begin
      $display("FAIL b2b_gap: busy=%b valid=%b expected 0 0", busy, dreq_valid); fails++;
    end
    tests++;
    issue(1'b0, 32'h0000_4002, 2'd1, 1'b1, 32'h0);
    if (dreq_valid !== 1'b1 || dreq_strobe !== 4'b0000 || dreq_addr !== 32'h4002 || dreq_size !== 2'd1) begin
      $display("FAIL b2b_ld: valid=%b strobe=%b addr=%h size=%0d expected 1 0000 4002 1",
               dreq_valid, dreq_strobe, dreq_addr, dreq_size); fails++;
    end
    tests++;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hF00D_1234;
    tick();
    bus_idle();
    if (done !== 1'b1 || rdata !== 32'hFFFF_F00D || txn_cnt - t0 !== 2) begin
      $display("FAIL b2b_done2: done=%b rdata=%h txns=%0d expected 1 fffff00d 2",
               done, rdata, txn_cnt - t0); fails++;
    end
    tests++;
    tick();
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_start_in_wait();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
